// File: rtl/mem_filter_copy.sv
// Scans a synchronous-read source memory and copies the words that match a
// selectable rule to consecutive destination addresses, reporting count and sum.
module mem_filter_copy #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     go,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        threshold,
  input  logic [ADDR_W:0]          num_words,
  output logic [ADDR_W-1:0]        src_addr,
  input  logic [DATA_W-1:0]        src_data,
  output logic                     dst_we,
  output logic [ADDR_W-1:0]        dst_addr,
  output logic [DATA_W-1:0]        dst_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          match_cnt,
  output logic [DATA_W+ADDR_W-1:0] sum
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EVAL, S_DONE} state_e;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         src_addr_q, src_addr_d;
  logic [ADDR_W:0]           match_cnt_q, match_cnt_d;
  logic [ADDR_W:0]           num_q, num_d;
  logic [DATA_W+ADDR_W-1:0]  sum_q, sum_d;
  logic [1:0]                mode_q, mode_d;
  logic [DATA_W-1:0]         thr_q, thr_d;
  logic                      match;
  logic                      last_word;

  // The source address register doubles as the scan index.
  always_comb begin
    unique case (mode_q)
      2'b00:   match = src_data[0];
      2'b01:   match = ~src_data[0];
      2'b10:   match = 1'b1;
      default: match = (src_data >= thr_q);
    endcase
  end

  assign last_word = ({1'b0, src_addr_q} == (num_q - CNT_ONE));

  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no
    // branch of the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    match_cnt_d = match_cnt_q;
    num_d       = num_q;
    sum_d       = sum_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    dst_we      = 1'b0;
    dst_addr    = '0;
    dst_data    = '0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          mode_d      = mode;
          thr_d       = threshold;
          num_d       = num_words;
          src_addr_d  = '0;
          match_cnt_d = '0;
          sum_d       = '0;
          state_d     = (num_words != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        state_d = abort ? S_DONE : S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        if (match && !abort) begin
          dst_we      = 1'b1;
          dst_addr    = match_cnt_q[ADDR_W-1:0];
          dst_data    = src_data;
          match_cnt_d = match_cnt_q + CNT_ONE;
          sum_d       = sum_q + {{ADDR_W{1'b0}}, src_data};
        end
        // Stopping on the last index keeps a full 2^ADDR_W scan from wrapping.
        if (last_word || abort) begin
          state_d = S_DONE;
        end else begin
          src_addr_d = src_addr_q + 1'b1;
          state_d    = S_READ;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      src_addr_q  <= '0;
      match_cnt_q <= '0;
      num_q       <= '0;
      sum_q       <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      match_cnt_q <= match_cnt_d;
      num_q       <= num_d;
      sum_q       <= sum_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
    end
  end

  assign src_addr  = src_addr_q;
  assign match_cnt = match_cnt_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_mem_filter_copy.sv
// Directed bench for mem_filter_copy: synchronous-read source memory model,
// destination writes captured per cycle and compared against hand-derived values.
module tb_mem_filter_copy;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic        abort;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic [4:0]  num_words;
  logic [3:0]  src_addr;
  logic [7:0]  src_data;
  logic        dst_we;
  logic [3:0]  dst_addr;
  logic [7:0]  dst_data;
  logic        busy;
  logic        done;
  logic [4:0]  match_cnt;
  logic [11:0] sum;

  logic [7:0]  mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-run observations filled by run_scan.
  logic [3:0]  wr_addr [$];
  logic [7:0]  wr_data [$];
  int          done_cyc;
  bit          odd_we;
  bit          idle_junk;
  bit          busy_gap;
  logic [3:0]  src_max;

  mem_filter_copy #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .abort     (abort),
    .mode      (mode),
    .threshold (threshold),
    .num_words (num_words),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .dst_we    (dst_we),
    .dst_addr  (dst_addr),
    .dst_data  (dst_data),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) src_data <= mem[src_addr];

  task automatic load_pattern();
    logic [7:0] pat [8] = '{8'd3, 8'd4, 8'd7, 8'd10, 8'd15, 8'd0, 8'd1, 8'd8};
    for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? pat[i] : 8'hEE;
  endtask

  // Pulses go (edge 0), then samples each cycle k just after its falling edge.
  task automatic run_scan(input logic [4:0] n, input logic [1:0] m,
                          input logic [7:0] thr, input int abort_cyc,
                          input int disturb_cyc);
    wr_addr.delete();
    wr_data.delete();
    done_cyc  = -1;
    odd_we    = 0;
    idle_junk = 0;
    busy_gap  = 0;
    src_max   = '0;
    @(negedge clk);
    mode = m; threshold = thr; num_words = n; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == abort_cyc)     abort = 1'b1;
      if (k == abort_cyc + 1) abort = 1'b0;
      if (k == disturb_cyc) begin
        go = 1'b1; mode = 2'b10; threshold = 8'hFF; num_words = 5'd2;
      end
      if (k == disturb_cyc + 1) go = 1'b0;
      #1;
      if (dst_we) begin
        wr_addr.push_back(dst_addr);
        wr_data.push_back(dst_data);
        if (k % 2 == 1) odd_we = 1;
      end else if (dst_addr !== 4'd0 || dst_data !== 8'd0) begin
        idle_junk = 1;
      end
      if (busy !== 1'b1) busy_gap = 1;
      if (src_addr > src_max) src_max = src_addr;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
    abort = 1'b0;
    go    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; go = 1'b0; abort = 1'b0; mode = 2'b00;
    threshold = 8'd0; num_words = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({busy, done, dst_we} !== 3'b000) begin n_bad++;
      $display("FAIL reset_ctrl: busy/done/we=%b want 000", {busy, done, dst_we}); end
    n_cmp++; if ({src_addr, match_cnt, sum, dst_addr, dst_data} !== '0) begin n_bad++;
      $display("FAIL reset_data: src_addr=%0d cnt=%0d sum=%0d want all 0", src_addr, match_cnt, sum); end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_odd_copy();
    logic [7:0] exp_d [4] = '{8'd3, 8'd7, 8'd15, 8'd1};
    load_pattern();
    run_scan(5'd8, 2'b00, 8'd0, -10, -10);
    n_cmp++; if (done_cyc != 17) begin n_bad++;
      $display("FAIL odd_done_cycle: got %0d want 17", done_cyc); end
    n_cmp++; if (wr_data.size() != 4) begin n_bad++;
      $display("FAIL odd_write_count: got %0d want 4", wr_data.size()); end
    for (int i = 0; i < 4 && i < wr_data.size(); i++) begin
      n_cmp++; if (wr_addr[i] !== 4'(i) || wr_data[i] !== exp_d[i]) begin n_bad++;
        $display("FAIL odd_write%0d: got %0d@%0d want %0d@%0d", i, wr_data[i], wr_addr[i], exp_d[i], i); end
    end
    n_cmp++; if (match_cnt !== 5'd4 || sum !== 12'd26) begin n_bad++;
      $display("FAIL odd_totals: cnt=%0d sum=%0d want 4/26", match_cnt, sum); end
    n_cmp++; if ({odd_we, idle_junk, busy_gap} !== 3'b000) begin n_bad++;
      $display("FAIL odd_we_timing: odd_we/junk/busy_gap=%b want 000", {odd_we, idle_junk, busy_gap}); end
  endtask

  task automatic test_modes();
    logic [1:0] md    [3] = '{2'b01, 2'b10, 2'b11};
    int         cnt   [3] = '{4, 8, 4};
    int         tot   [3] = '{22, 48, 40};
    logic [7:0] exp_d [3][8] = '{'{8'd4, 8'd10, 8'd0, 8'd8, 0, 0, 0, 0},
                                 '{8'd3, 8'd4, 8'd7, 8'd10, 8'd15, 8'd0, 8'd1, 8'd8},
                                 '{8'd7, 8'd10, 8'd15, 8'd8, 0, 0, 0, 0}};
    load_pattern();
    for (int t = 0; t < 3; t++) begin
      run_scan(5'd8, md[t], 8'd7, -10, -10);
      n_cmp++; if (wr_data.size() != cnt[t] || match_cnt !== 5'(cnt[t]) || sum !== 12'(tot[t])) begin
        n_bad++;
        $display("FAIL mode%0d_totals: writes=%0d cnt=%0d sum=%0d want %0d/%0d/%0d",
                 md[t], wr_data.size(), match_cnt, sum, cnt[t], cnt[t], tot[t]); end
      for (int i = 0; i < cnt[t] && i < wr_data.size(); i++) begin
        n_cmp++; if (wr_addr[i] !== 4'(i) || wr_data[i] !== exp_d[t][i]) begin n_bad++;
          $display("FAIL mode%0d_write%0d: got %0d@%0d want %0d@%0d", md[t], i,
                   wr_data[i], wr_addr[i], exp_d[t][i], i); end
      end
    end
  endtask

  task automatic test_num_zero();
    run_scan(5'd0, 2'b10, 8'd0, -10, -10);
    n_cmp++; if (done_cyc != 1) begin n_bad++;
      $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    n_cmp++; if (wr_data.size() != 0 || src_max !== 4'd0) begin n_bad++;
      $display("FAIL zero_activity: writes=%0d max_src=%0d want 0/0", wr_data.size(), src_max); end
    n_cmp++; if (match_cnt !== 5'd0 || sum !== 12'd0) begin n_bad++;
      $display("FAIL zero_totals: cnt=%0d sum=%0d want 0/0", match_cnt, sum); end
  endtask

  task automatic test_full_range();
    for (int i = 0; i < 16; i++) mem[i] = 8'd255;
    run_scan(5'd16, 2'b10, 8'd0, -10, -10);
    n_cmp++; if (done_cyc != 33 || wr_data.size() != 16) begin n_bad++;
      $display("FAIL full_run: done_cycle=%0d writes=%0d want 33/16", done_cyc, wr_data.size()); end
    if (wr_addr.size() == 16) begin
      n_cmp++; if (wr_addr[15] !== 4'd15 || src_max !== 4'd15) begin n_bad++;
        $display("FAIL full_last_addr: dst=%0d src_max=%0d want 15/15", wr_addr[15], src_max); end
    end
    n_cmp++; if (match_cnt !== 5'd16 || sum !== 12'd4080) begin n_bad++;
      $display("FAIL full_totals: cnt=%0d sum=%0d want 16/4080", match_cnt, sum); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || dst_we !== 1'b0) begin n_bad++;
      $display("FAIL full_no_wrap: busy=%b we=%b want 0/0", busy, dst_we); end
  endtask

  task automatic test_abort();
    load_pattern();
    run_scan(5'd8, 2'b00, 8'd0, 6, -10);
    n_cmp++; if (done_cyc != 7) begin n_bad++;
      $display("FAIL abort_done_cycle: got %0d want 7", done_cyc); end
    n_cmp++; if (wr_data.size() != 1 || match_cnt !== 5'd1 || sum !== 12'd3) begin n_bad++;
      $display("FAIL abort_totals: writes=%0d cnt=%0d sum=%0d want 1/1/3", wr_data.size(), match_cnt, sum); end
  endtask

  task automatic test_reset_mid_run();
    load_pattern();
    @(negedge clk);
    mode = 2'b00; num_words = 5'd8; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (dst_we !== 1'b1 || dst_data !== 8'd3) begin n_bad++;
      $display("FAIL midrst_pre: we=%b data=%0d want 1/3", dst_we, dst_data); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({dst_we, busy, done} !== 3'b000 || {dst_addr, dst_data, src_addr, match_cnt, sum} !== '0) begin
      n_bad++;
      $display("FAIL midrst_async: we/busy/done=%b data=%0d cnt=%0d want 000/0/0",
               {dst_we, busy, done}, dst_data, match_cnt); end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || dst_we !== 1'b0) begin n_bad++;
      $display("FAIL midrst_idle: busy=%b we=%b want 0/0", busy, dst_we); end
  endtask

  task automatic test_go_while_busy();
    load_pattern();
    run_scan(5'd8, 2'b00, 8'd0, -10, 3);
    n_cmp++; if (done_cyc != 17 || wr_data.size() != 4) begin n_bad++;
      $display("FAIL busy_go_run: done_cycle=%0d writes=%0d want 17/4", done_cyc, wr_data.size()); end
    n_cmp++; if (match_cnt !== 5'd4 || sum !== 12'd26) begin n_bad++;
      $display("FAIL busy_go_totals: cnt=%0d sum=%0d want 4/26", match_cnt, sum); end
  endtask

  task automatic test_back_to_back();
    int k;
    load_pattern();
    @(negedge clk);
    mode = 2'b00; num_words = 5'd8; go = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1 k++;
    end while (done !== 1'b1 && k < 40);
    n_cmp++; if (done !== 1'b1) begin n_bad++;
      $display("FAIL b2b_first_done: no done within %0d cycles", k); end
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || match_cnt !== 5'd4) begin n_bad++;
      $display("FAIL b2b_idle: busy=%b cnt=%0d want 0/4", busy, match_cnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1 || match_cnt !== 5'd0 || sum !== 12'd0) begin n_bad++;
      $display("FAIL b2b_restart: busy=%b cnt=%0d sum=%0d want 1/0/0", busy, match_cnt, sum); end
    go = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (dst_we !== 1'b1 || dst_addr !== 4'd0 || dst_data !== 8'd3) begin n_bad++;
      $display("FAIL b2b_first_write: we=%b %0d@%0d want 1 3@0", dst_we, dst_data, dst_addr); end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      #1 k++;
    end
    n_cmp++; if (done !== 1'b1 || match_cnt !== 5'd4 || sum !== 12'd26) begin n_bad++;
      $display("FAIL b2b_second_run: done=%b cnt=%0d sum=%0d want 1/4/26", done, match_cnt, sum); end
  endtask

  initial begin
    test_reset();
    test_odd_copy();
    test_modes();
    test_num_zero();
    test_full_range();
    test_abort();
    test_reset_mid_run();
    test_go_while_busy();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_filter_copy.md
Name: mem_filter_copy

Overview:
- Parametrised successor to the lab-1 odd-value copy controller, with its datapath built in.
- On go, scans num_words entries of a synchronous-read source memory and writes each matching entry to consecutive addresses of a destination memory.
- Match rule is selected by mode: odd, even, all, or at-least-threshold.
- Reports the match count and the sum of the copied values; supports abort and a one-cycle done pulse.

Parameters:
- DATA_W, 8, width of source/destination data words.
- ADDR_W, 4, address width; at most 2^ADDR_W words are scanned.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; honoured in READ and EVAL.
- mode  in  2  00 odd, 01 even, 10 all, 11 value >= threshold (unsigned).
- threshold  in  DATA_W  compare value for mode 11.
- num_words  in  ADDR_W+1  number of words to scan, 0..2^ADDR_W.
- src_addr  out  ADDR_W  source read address, registered.
- src_data  in  DATA_W  source data; valid one cycle after src_addr.
- dst_we  out  1  destination write enable.
- dst_addr  out  ADDR_W  destination write address.
- dst_data  out  DATA_W  destination write data.
- busy  out  1  high in READ, EVAL and DONE.
- done  out  1  one-cycle pulse in DONE.
- match_cnt  out  ADDR_W+1  words written in the current or last run.
- sum  out  DATA_W+ADDR_W  unsigned sum of the words written; cannot overflow.

Behaviour:
- Reset: state IDLE. src_addr, match_cnt, sum, internal index and latched config = 0. dst_we, busy, done = 0.
- Reset mid-run: dst_we drops immediately (async); no further writes.

- IDLE:
  - go=1 latches mode, threshold and num_words, and clears index, match_cnt and sum.
  - Next state is READ if num_words != 0, else DONE.
  - match_cnt and sum keep their last-run values until the next accepted go.
- READ:
  - src_addr = index (registered).
  - Next state is EVAL, or DONE if abort=1.
- EVAL:
  - src_data is valid. match is evaluated combinationally against the latched mode/threshold.
  - If match and abort=0:
    - dst_we = 1, dst_addr = match_cnt[ADDR_W-1:0], dst_data = src_data.
    - On the clock edge: match_cnt += 1, sum += src_data (zero-extended).
  - If index == num_words-1 or abort=1, next state is DONE; otherwise index += 1 and next state is READ.
  - abort in EVAL suppresses that cycle's write.
- DONE:
  - done = 1 for exactly one cycle, busy = 1; next state is IDLE.
- Timing:
  - 2 cycles per word.
  - For N >= 1 words with go sampled at edge 0: done is high during cycle 2N+1.
  - For N = 0: done is high during cycle 1.
- dst_we, dst_addr and dst_data are combinational from state and inputs; dst_we = 0 outside EVAL. dst_addr and dst_data are 0 whenever dst_we = 0.
- go outside IDLE is ignored; go held high re-triggers on the cycle after DONE.
- abort in IDLE or DONE is ignored.
- Changes to mode, threshold or num_words during a run have no effect.
- Index range is 0..num_words-1. When num_words = 2^ADDR_W, the final src_addr is all ones and the index does not wrap into a second pass.
- Odd is src_data[0]=1; even is src_data[0]=0.

Test Plan:
All cases use DATA_W=8, ADDR_W=4.
- Odd copy: src = {3,4,7,10,15,0,1,8}, num_words=8, mode=00, go pulse → dst writes 3@0, 7@1, 15@2, 1@3; match_cnt=4, sum=26; done in cycle 17; no dst_we in other cycles.
- Modes: same src with mode=01 → dst {4,10,0,8}, match_cnt=4, sum=22. mode=10 → 8 writes, sum=48. mode=11 with threshold=7 → dst {7,10,15,8}, sum=40.
- Boundaries:
  - num_words=0 → done in cycle 1, no src/dst activity, match_cnt=0, sum=0.
  - num_words=16 with all words 255, mode=10 → 16 writes, last dst_addr=15, match_cnt=16, sum=4080, no wrap.
- Abort: abort=1 during the EVAL of word 2 (value 7, odd run) → no write of 7, DONE next cycle, match_cnt=1, sum=3.
- Reset mid-run: reset_n low during an EVAL cycle with a match → dst_we falls without a clock edge, all outputs 0; after release, IDLE with busy=0.
- go while busy: go asserted during a run → ignored and the latched config is unchanged. go held high through DONE → a new run starts the following cycle, with match_cnt cleared.
